// File: rtl/mc_pkg.sv
// Shared constants, FSM state type and error codes for the missionaries-and-cannibals move checker.
package mc_pkg;

  localparam logic [1:0] N_PEOPLE = 2'd3;
  localparam logic [2:0] BOAT_CAP = 3'd2;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DONE = 2'd1,
    FAIL = 2'd2
  } mc_state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_BAD_LOAD = 2'b01;
  localparam logic [1:0] ERR_SHORTAGE = 2'b10;
  localparam logic [1:0] ERR_UNSAFE   = 2'b11;

endpackage

// File: rtl/mc_bank_safe.sv
// A bank is safe unless missionaries are present and outnumbered by cannibals.
module mc_bank_safe (
  input  logic [1:0] m,
  input  logic [1:0] c,
  output logic       safe
);

  assign safe = !((m != 2'd0) && (c > m));

endmodule

// File: rtl/mc_move_checker.sv
// Move-stream referee: validates boat loads, tracks bank state, sticky err/done.
// Optional move log enabled by defining MC_CHECK_HIST_EN.
module mc_move_checker
  import mc_pkg::*;
#(
  parameter int CNT_W      = 4,
  parameter int HIST_DEPTH = 16,
  localparam int HW        = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             mv_valid,
  input  logic [1:0]       mv_m,
  input  logic [1:0]       mv_c,
  output logic             mv_ready,
  output logic [1:0]       left_m,
  output logic [1:0]       left_c,
  output logic             side,
  output logic [CNT_W-1:0] move_cnt,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  input  logic [HW-1:0]    hist_idx,
  output logic [4:0]       hist_data
);

  mc_state_e        state_q, state_d;
  logic [1:0]       lm_q, lm_d, lc_q, lc_d, code_q, code_d;
  logic             side_q, side_d, done_q, done_d, err_q, err_d, rdy_q, rdy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept, legal, safe_l, safe_r;
  logic [1:0]       sm, sc, nlm, nlc;
  logic [2:0]       tot;

  assign accept = mv_valid & rdy_q;
  assign tot    = {1'b0, mv_m} + {1'b0, mv_c};
  assign sm     = side_q ? (N_PEOPLE - lm_q) : lm_q;
  assign sc     = side_q ? (N_PEOPLE - lc_q) : lc_q;
  assign nlm    = side_q ? (lm_q + mv_m) : (lm_q - mv_m);
  assign nlc    = side_q ? (lc_q + mv_c) : (lc_q - mv_c);

  // Post-move counts can wrap on a shortage; shortage outranks unsafe, so it never matters.
  mc_bank_safe u_safe_left  (.m(nlm),            .c(nlc),            .safe(safe_l));
  mc_bank_safe u_safe_right (.m(N_PEOPLE - nlm), .c(N_PEOPLE - nlc), .safe(safe_r));

  always_comb begin
    state_d = state_q;
    lm_d    = lm_q;
    lc_d    = lc_q;
    side_d  = side_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    err_d   = err_q;
    code_d  = code_q;
    legal   = 1'b0;
    if (clr) begin
      state_d = RUN;
      lm_d    = N_PEOPLE;
      lc_d    = N_PEOPLE;
      side_d  = 1'b0;
      cnt_d   = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      code_d  = ERR_NONE;
    end else if (accept) begin
      if (tot == 3'd0 || tot > BOAT_CAP) begin
        state_d = FAIL;
        err_d   = 1'b1;
        code_d  = ERR_BAD_LOAD;
      end else if (mv_m > sm || mv_c > sc) begin
        state_d = FAIL;
        err_d   = 1'b1;
        code_d  = ERR_SHORTAGE;
      end else if (!(safe_l && safe_r)) begin
        state_d = FAIL;
        err_d   = 1'b1;
        code_d  = ERR_UNSAFE;
      end else begin
        legal  = 1'b1;
        lm_d   = nlm;
        lc_d   = nlc;
        side_d = ~side_q;
        cnt_d  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        if (nlm == 2'd0 && nlc == 2'd0 && !side_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
    end
    rdy_d = (state_d == RUN);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= RUN;
      lm_q    <= N_PEOPLE;
      lc_q    <= N_PEOPLE;
      side_q  <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lm_q    <= lm_d;
      lc_q    <= lc_d;
      side_q  <= side_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      rdy_q   <= rdy_d;
    end
  end

  assign mv_ready = rdy_q;
  assign left_m   = lm_q;
  assign left_c   = lc_q;
  assign side     = side_q;
  assign move_cnt = cnt_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = code_q;

`ifdef MC_CHECK_HIST_EN
  logic [4:0]    log_mem [HIST_DEPTH];
  logic [HW-1:0] wptr_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                   wptr_q <= '0;
    else if (clr)               wptr_q <= '0;
    else if (legal)
      wptr_q <= (wptr_q == HW'(HIST_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
  end

  // Contents deliberately unreset; only the pointer restarts.
  always_ff @(posedge CLK) begin
    if (legal && !clr) log_mem[wptr_q] <= {side_q, mv_m, mv_c};
  end

  assign hist_data = log_mem[hist_idx];
`else
  logic unused_hist;
  assign unused_hist = ^{hist_idx, legal};
  assign hist_data   = 5'd0;
`endif

endmodule

// File: tb/tb_mc_move_checker.sv
// Directed self-checking bench for mc_move_checker (hand-computed expectations).
module tb_mc_move_checker;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       clr = 1'b0;
  logic       mv_valid = 1'b0;
  logic [1:0] mv_m = 2'd0, mv_c = 2'd0;
  logic       mv_ready, side, done, err;
  logic [1:0] left_m, left_c, err_code;
  logic [3:0] move_cnt;
  logic [3:0] hist_idx = 4'd0;
  logic [4:0] hist_data;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  mc_move_checker #(.CNT_W(4), .HIST_DEPTH(16)) dut (
    .CLK(CLK), .RST(RST), .clr(clr), .mv_valid(mv_valid), .mv_m(mv_m), .mv_c(mv_c),
    .mv_ready(mv_ready), .left_m(left_m), .left_c(left_c), .side(side),
    .move_cnt(move_cnt), .done(done), .err(err), .err_code(err_code),
    .hist_idx(hist_idx), .hist_data(hist_data)
  );

  // Present one load per edge, back to back; inputs change on falling edges.
  task automatic moves(input logic [1:0] ms[], input logic [1:0] cs[]);
    for (int i = 0; i < ms.size(); i++) begin
      @(negedge CLK);
      mv_valid = 1'b1; mv_m = ms[i]; mv_c = cs[i];
      @(posedge CLK);
    end
    @(negedge CLK);
    mv_valid = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge CLK); clr = 1'b1;
    @(negedge CLK); clr = 1'b0;
  endtask

  task automatic chk_state(input string nm, input logic [1:0] em, input logic [1:0] ec,
                           input logic es, input logic [3:0] ecnt, input logic erdy,
                           input logic edone, input logic eerr, input logic [1:0] ecode);
    checks++;
    if ({left_m, left_c, side, move_cnt, mv_ready, done, err, err_code} !==
        {em, ec, es, ecnt, erdy, edone, eerr, ecode}) begin
      failures++;
      $display("FAIL %s: got m=%0d c=%0d side=%0d cnt=%0d rdy=%0d done=%0d err=%0d code=%0d, want m=%0d c=%0d side=%0d cnt=%0d rdy=%0d done=%0d err=%0d code=%0d",
               nm, left_m, left_c, side, move_cnt, mv_ready, done, err, err_code,
               em, ec, es, ecnt, erdy, edone, eerr, ecode);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; #12;
    chk_state("reset_low", 2'd3, 2'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK);
    chk_state("reset_release", 2'd3, 2'd3, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic test_solve();
    moves('{2'd0,2'd0,2'd0,2'd0,2'd2,2'd1,2'd2,2'd0,2'd0,2'd0,2'd0},
          '{2'd2,2'd1,2'd2,2'd1,2'd0,2'd1,2'd0,2'd1,2'd2,2'd1,2'd2});
    chk_state("solve_11", 2'd0, 2'd0, 1'b1, 4'd11, 1'b0, 1'b1, 1'b0, 2'b00);
    moves('{2'd0}, '{2'd1});
    chk_state("done_ignores_move", 2'd0, 2'd0, 1'b1, 4'd11, 1'b0, 1'b1, 1'b0, 2'b00);
`ifdef MC_CHECK_HIST_EN
    hist_idx = 4'd4; #1;
    checks++;
    if (hist_data !== 5'b0_10_00) begin
      failures++; $display("FAIL hist_idx4: got %b want %b", hist_data, 5'b0_10_00);
    end
    hist_idx = 4'd1; #1;
    checks++;
    if (hist_data !== 5'b1_00_01) begin
      failures++; $display("FAIL hist_idx1: got %b want %b", hist_data, 5'b1_00_01);
    end
`else
    hist_idx = 4'd4; #1;
    checks++;
    if (hist_data !== 5'd0) begin
      failures++; $display("FAIL hist_tied: got %b want 00000", hist_data);
    end
`endif
  endtask

  task automatic test_clr();
    do_clr();
    chk_state("clr_restore", 2'd3, 2'd3, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic test_bad_load();
    moves('{2'd0}, '{2'd0});
    chk_state("bad_load_zero", 2'd3, 2'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 2'b01);
    moves('{2'd0}, '{2'd1});
    chk_state("fail_sticky", 2'd3, 2'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 2'b01);
    do_clr();
    moves('{2'd2}, '{2'd1});
    chk_state("bad_load_three", 2'd3, 2'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 2'b01);
  endtask

  task automatic test_shortage();
    do_clr();
    moves('{2'd0, 2'd2}, '{2'd2, 2'd0});
    chk_state("shortage", 2'd3, 2'd1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 2'b10);
  endtask

  task automatic test_unsafe();
    do_clr();
    moves('{2'd1}, '{2'd0});
    chk_state("unsafe", 2'd3, 2'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 2'b11);
  endtask

  task automatic test_saturation();
    logic [1:0] ms[];
    logic [1:0] cs[];
    do_clr();
    ms = new[17]; cs = new[17];
    foreach (ms[i]) begin ms[i] = 2'd0; cs[i] = 2'd1; end
    moves(ms, cs);
    chk_state("cnt_saturate", 2'd3, 2'd2, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic test_rst_mid();
    do_clr();
    moves('{2'd0,2'd0,2'd0,2'd0}, '{2'd2,2'd1,2'd2,2'd1});
    chk_state("four_moves", 2'd3, 2'd1, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 2'b00);
    @(posedge CLK); #3 RST = 1'b0; #1;
    chk_state("async_reset", 2'd3, 2'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_clr_with_move();
    @(negedge CLK);
    clr = 1'b1; mv_valid = 1'b1; mv_m = 2'd0; mv_c = 2'd2;
    @(negedge CLK);
    clr = 1'b0; mv_valid = 1'b0;
    chk_state("clr_beats_move", 2'd3, 2'd3, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
  endtask

  initial begin
    test_reset();
    test_solve();
    test_clr();
    test_bad_load();
    test_shortage();
    test_unsafe();
    test_saturation();
    test_rst_mid();
    test_clr_with_move();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_move_checker.md
# mc_move_checker

Move-stream referee for the missionaries-and-cannibals puzzle. It is the receiving end of the move stream that the solver produces. It accepts one boat load per handshake and tracks the left-bank missionary and cannibal counts and the boat side. It rejects illegal loads with a sticky error code and flags completion when everyone has reached the right bank.

## Interface
Parameters:
- CNT_W, 4, width of the accepted-move counter; the counter saturates at 2^CNT_W−1.
- HIST_DEPTH, 16, number of move-log entries; only used with MC_CHECK_HIST_EN.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous soft restart to the initial puzzle state.
- mv_valid  in  1  a boat load is presented.
- mv_m  in  2  missionaries in the boat (0–3).
- mv_c  in  2  cannibals in the boat (0–3).
- mv_ready  out  1  checker can accept a load.
- left_m  out  2  missionaries on the left bank.
- left_c  out  2  cannibals on the left bank.
- side  out  1  boat position: 0 = left, 1 = right.
- move_cnt  out  CNT_W  number of accepted legal moves.
- done  out  1  puzzle solved; sticky.
- err  out  1  illegal move seen; sticky.
- err_code  out  2  00 none, 01 BAD_LOAD, 10 SHORTAGE, 11 UNSAFE.
- hist_idx  in  log2(HIST_DEPTH)  move-log read index.
- hist_data  out  5  log entry {side_before, m[1:0], c[1:0]}.

## Operation
- FSM states:
  - RUN: mv_ready = 1.
  - DONE: mv_ready = 0.
  - FAIL: mv_ready = 0.
- Reset state and values: RUN, left_m = 3, left_c = 3, side = 0, move_cnt = 0, done = 0, err = 0, err_code = 00. mv_ready = 0 while RST is low.
- A move is accepted on a rising edge with mv_valid & mv_ready. mv_valid without mv_ready is ignored.
- Bank arithmetic:
  - The bank on the boat side is the source, holding sm/sc. sm/sc = left counts when side = 0, otherwise 3 − left counts.
  - The load total is t = mv_m + mv_c, computed 3 bits wide.
- Checks, evaluated in priority order:
  1. BAD_LOAD: t = 0 or t > 2.
  2. SHORTAGE: mv_m > sm or mv_c > sc.
  3. UNSAFE: after the move, either bank has m > 0 and c > m.
- Legal move:
  - Update left_m/left_c: subtract the load when side = 0, add it when side = 1.
  - Toggle side.
  - Increment move_cnt, saturating at 2^CNT_W−1; saturation is not an error.
- Illegal move:
  - Bank state, side and move_cnt are unchanged.
  - err = 1 and err_code is loaded with the reason.
  - FSM → FAIL.
- RUN → DONE when the new state after a legal move is left_m = 0, left_c = 0, side = 1. done = 1 in that case.
- DONE and FAIL are left only through clr or RST.
- clr in any state restores all reset values, clears the log write pointer, and sets FSM → RUN.
- clr together with an accepted mv_valid: clr wins and the move is dropped.

## Timing
- All outputs except hist_data are registered.
- Bank state, err, err_code and done are visible the cycle after the accepting edge. mv_ready falls in that same cycle.
- Throughput is one move per cycle while in RUN; back-to-back moves are checked against the updated state.
- RST assertion mid-sequence clears everything immediately, without waiting for a clock.

## Configuration
- Macro MC_CHECK_HIST_EN.
- When defined:
  - A HIST_DEPTH-entry log records each accepted legal move at the write pointer; the pointer then increments.
  - The log wraps at HIST_DEPTH.
  - hist_data = log[hist_idx], read combinationally.
  - Log contents are not reset; only the pointer is.
- When undefined: no log storage, hist_data is tied to 0, and hist_idx is unused.

## Structure
- Package mc_pkg holds:
  - constants N_PEOPLE = 3 and BOAT_CAP = 2;
  - the FSM state enum {RUN, DONE, FAIL};
  - the err_code localparams ERR_NONE, ERR_BAD_LOAD, ERR_SHORTAGE, ERR_UNSAFE.
- Sub-module mc_bank_safe: combinational, inputs m[1:0] and c[1:0], output safe. It is instanced twice, once for the left bank and once for the right bank after the move.

## Test plan
- Optimal 11-move sequence (0,2),(0,1),(0,2),(0,1),(2,0),(1,1),(2,0),(0,1),(0,2),(0,1),(0,2) → done = 1 after the 11th move, move_cnt = 11, left 0/0, side = 1, mv_ready = 0.
- First move (0,0) → err_code = 01, left still 3/3, side = 0.
- First move (0,2), then (2,0) from the right bank → err_code = 10, left_c = 1, side = 1.
- First move (1,0) → left would be 2/3 → err_code = 11, move_cnt = 0.
- Four legal moves, then RST pulsed low between clock edges → immediate reset values; clr asserted together with mv_valid → move dropped, state 3/3/0.
- With MC_CHECK_HIST_EN, the 11-move sequence then hist_idx = 4 → hist_data = {0, 2'd2, 2'd0}.
